// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier: one partial product per clock around a WIDTH+1 bit adder.
// Optional feature macro: MUL_OVF_FLAG_EN adds the ovf output (product does not fit in WIDTH bits).
module shift_add_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
`ifdef MUL_OVF_FLAG_EN
  output logic                 ovf,
`endif
  output logic [2*WIDTH-1:0]   product
);

  // state | meaning
  // IDLE  | waiting for start; product holds last result
  // RUN   | one add/shift step per cycle, WIDTH steps
  // DONE  | single cycle, done pulse, product valid
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   lo;
  logic [CNT_W-1:0]   counter;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic               last_step;

  // Carry-out lands in sum[WIDTH] and is shifted into the accumulator MSB.
  assign sum       = {1'b0, acc_hi} + ({1'b0, mcand_r} & {(WIDTH+1){lo[0]}});
  assign prod_nxt  = {sum, lo[WIDTH-1:1]};
  assign last_step = (counter == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r <= '0;
      acc_hi  <= '0;
      lo      <= '0;
      counter <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          mcand_r <= mcand;
          lo      <= mplier;
          acc_hi  <= '0;
          counter <= '0;
        end
        RUN: begin
          acc_hi  <= sum[WIDTH:1];
          lo      <= {sum[0], lo[WIDTH-1:1]};
          counter <= counter + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result register only loads on the final step so it is stable in IDLE and RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product <= '0;
`ifdef MUL_OVF_FLAG_EN
      ovf     <= 1'b0;
`endif
    end else if (state == RUN && last_step) begin
      product <= prod_nxt;
`ifdef MUL_OVF_FLAG_EN
      ovf     <= |prod_nxt[2*WIDTH-1:WIDTH];
`endif
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (WIDTH=32) with an expected-product scoreboard.
// Checks ovf as well when MUL_OVF_FLAG_EN is defined.
module tb_shift_add_multiplier;
  localparam int WIDTH = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
`ifdef MUL_OVF_FLAG_EN
  logic                 ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [2*WIDTH-1:0] sb_q[$];

  shift_add_multiplier #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
`ifdef MUL_OVF_FLAG_EN
    .ovf     (ovf),
`endif
    .product (product)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [2*WIDTH-1:0] obs, input logic [2*WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag);
    logic [2*WIDTH-1:0] e;
    check({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_product"}, product, e);
`ifdef MUL_OVF_FLAG_EN
      check({tag, "_ovf"}, 64'(ovf), 64'(|e[2*WIDTH-1:WIDTH]));
`endif
    end
  endtask

  // inj != 0: pulse start (9*9) during RUN at that cycle after the accepting edge
  task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2*WIDTH-1:0] exp, input int inj);
    int bcnt;
    int lat;
    logic [2*WIDTH-1:0] prev;
    @(posedge clk); #1;
    prev   = product;
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    start  = 1'b0;
    mcand  = $urandom;
    mplier = $urandom;
    bcnt = 0;
    lat  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (inj != 0 && k == inj) begin
        start  = 1'b1;
        mcand  = 32'd9;
        mplier = 32'd9;
      end
      if (inj != 0 && k == inj + 1) start = 1'b0;
      if (busy === 1'b1) bcnt++;
      if (k == 10) check({tag, "_product_stable_run"}, product, prev);
      if (done === 1'b1) begin
        lat = k;
        check_result(tag);
        break;
      end
    end
    check({tag, "_done_latency"}, 64'(lat), 64'(WIDTH + 1));
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(WIDTH));
    @(negedge clk);
    check({tag, "_done_single"}, 64'(done), 64'd0);
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int d_before;
    int d1;
    int d2;
    reset  = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    #2;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_op("t1_3x5", 32'd3, 32'd5, 64'h0F, 0);
    do_op("t2_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    do_op("t3_mplier0", 32'h1234_5678, 32'd0, 64'd0, 0);
    do_op("t3_mcand0", 32'd0, 32'd7, 64'd0, 0);

    d_before = done_cnt;
    do_op("t4_6x7", 32'd6, 32'd7, 64'd42, 10);
    repeat (40) @(posedge clk);
    #1;
    check("t4_no_extra_done", 64'(done_cnt - d_before), 64'd1);
    check("t4_product_held", product, 64'd42);

    // abort a running op with asynchronous reset mid-cycle
    d_before = done_cnt;
    @(posedge clk); #1;
    start  = 1'b1;
    mcand  = 32'd100;
    mplier = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t5_async_busy", 64'(busy), 64'd0);
    check("t5_async_done", 64'(done), 64'd0);
    check("t5_async_product", product, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("t5_no_done_after_abort", 64'(done_cnt - d_before), 64'd0);
    do_op("t5_2x2", 32'd2, 32'd2, 64'd4, 0);

    // start held high: back-to-back operations
    @(posedge clk); #1;
    start  = 1'b1;
    mcand  = 32'd10;
    mplier = 32'd10;
    sb_q.push_back(64'd100);
    sb_q.push_back(64'h1_0000_0000);
    @(posedge clk); #1;
    mcand  = 32'd65536;
    mplier = 32'd65536;
    d1 = 0;
    d2 = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 36) start = 1'b0;
      if (done === 1'b1) begin
        if (d1 == 0) begin
          d1 = k;
          check_result("t6_first");
        end else if (d2 == 0) begin
          d2 = k;
          check_result("t6_second");
        end
      end
    end
    check("t6_first_latency", 64'(d1), 64'd33);
    check("t6_second_latency", 64'(d2), 64'd67);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
